// File: rtl/pipeline_4_writeback.sv
// Writeback stage and 8x16 register file for the pipelined core.
// Three bypassed read ports plus a per-register pending-write scoreboard.
module pipeline_4_writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic        valid_in,
  input  logic        we_in,
  input  logic [2:0]  num_Rd_in,
  input  logic [15:0] result_in,
  input  logic        issue_valid,
  input  logic [2:0]  issue_Rd,
  input  logic [2:0]  num_Rm,
  input  logic [2:0]  num_Rn,
  input  logic [2:0]  num_Rram,
  input  logic        use_Rm,
  input  logic        use_Rn,
  input  logic        use_Rram,
  output logic [15:0] data_Rm,
  output logic [15:0] data_Rn,
  output logic [15:0] data_Rram,
  output logic        hazard,
  output logic        retire,
  output logic        err_overflow,
  output logic        err_underflow
);

  logic        wb_valid_q;
  logic        wb_we_q;
  logic [2:0]  wb_rd_q;
  logic [15:0] wb_data_q;
  logic [15:0] rf_q  [8];
  logic [1:0]  cnt_q [8];
  logic [1:0]  cnt_d [8];
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        commit;

  assign commit = wb_valid_q & wb_we_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= update & valid_in;
      if (update) begin
        wb_we_q   <= we_in;
        wb_rd_q   <= num_Rd_in;
        wb_data_q <= result_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else if (commit) begin
      rf_q[wb_rd_q] <= wb_data_q;
    end
  end

  // Issue and commit to the same register cancel out.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue_valid && issue_Rd == 3'(r) &&
          !(commit && wb_rd_q == 3'(r))) begin
        if (cnt_q[r] == 2'd3) ovf_d = 1'b1;
        else cnt_d[r] = cnt_q[r] + 2'd1;
      end else if (commit && wb_rd_q == 3'(r) &&
                   !(issue_valid && issue_Rd == 3'(r))) begin
        if (cnt_q[r] == 2'd0) unf_d = 1'b1;
        else cnt_d[r] = cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  function automatic logic [15:0] rd_port(input logic [2:0] n);
    return (commit && wb_rd_q == n) ? wb_data_q : rf_q[n];
  endfunction

  // A last pending write committing now is covered by bypass.
  function automatic logic pend(input logic u, input logic [2:0] n);
    return u && cnt_q[n] != 2'd0 &&
           !(commit && wb_rd_q == n && cnt_q[n] == 2'd1);
  endfunction

  assign data_Rm       = rd_port(num_Rm);
  assign data_Rn       = rd_port(num_Rn);
  assign data_Rram     = rd_port(num_Rram);
  assign hazard        = pend(use_Rm, num_Rm) |
                         pend(use_Rn, num_Rn) |
                         pend(use_Rram, num_Rram);
  assign retire        = commit;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule

// File: tb/tb_pipeline_4_writeback.sv
// Self-checking bench for pipeline_4_writeback.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_pipeline_4_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        update, valid_in, we_in;
  logic [2:0]  num_Rd_in;
  logic [15:0] result_in;
  logic        issue_valid;
  logic [2:0]  issue_Rd;
  logic [2:0]  num_Rm, num_Rn, num_Rram;
  logic        use_Rm, use_Rn, use_Rram;
  logic [15:0] data_Rm, data_Rn, data_Rram;
  logic        hazard, retire, err_overflow, err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  pipeline_4_writeback dut (
    .clk(clk), .rst(rst),
    .update(update), .valid_in(valid_in), .we_in(we_in),
    .num_Rd_in(num_Rd_in), .result_in(result_in),
    .issue_valid(issue_valid), .issue_Rd(issue_Rd),
    .num_Rm(num_Rm), .num_Rn(num_Rn), .num_Rram(num_Rram),
    .use_Rm(use_Rm), .use_Rn(use_Rn), .use_Rram(use_Rram),
    .data_Rm(data_Rm), .data_Rn(data_Rn), .data_Rram(data_Rram),
    .hazard(hazard), .retire(retire),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: architectural values, pending counts, one in-flight entry.
  int        m_rf  [8];
  int        m_cnt [8];
  bit        m_full;
  int        m_rd;
  int        m_val;
  bit        m_ovf, m_unf;

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin m_rf[i] = 0; m_cnt[i] = 0; end
    m_full = 0; m_rd = 0; m_val = 0; m_ovf = 0; m_unf = 0;
  endtask

  function automatic int m_data(input int n);
    if (m_full && m_rd == n) return m_val;
    return m_rf[n];
  endfunction

  function automatic bit m_wait(input bit u, input int n);
    int left;
    if (!u) return 0;
    left = m_cnt[n];
    if (m_full && m_rd == n) left = left - 1;
    return left > 0;
  endfunction

  function automatic bit m_hazard();
    return m_wait(use_Rm, num_Rm) || m_wait(use_Rn, num_Rn) ||
           m_wait(use_Rram, num_Rram);
  endfunction

  task automatic m_step();
    int delta [8];
    for (int i = 0; i < 8; i++) delta[i] = 0;
    if (issue_valid) delta[issue_Rd] += 1;
    if (m_full) begin
      delta[m_rd] -= 1;
      m_rf[m_rd] = m_val;
    end
    for (int i = 0; i < 8; i++) begin
      if (m_cnt[i] + delta[i] > 3) m_ovf = 1;
      else if (m_cnt[i] + delta[i] < 0) m_unf = 1;
      else m_cnt[i] = m_cnt[i] + delta[i];
    end
    m_full = update && valid_in && we_in;
    if (m_full) begin m_rd = num_Rd_in; m_val = result_in; end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic idle();
    update = 0; valid_in = 0; we_in = 0;
    num_Rd_in = 0; result_in = 0;
    issue_valid = 0; issue_Rd = 0;
    num_Rm = 0; num_Rn = 0; num_Rram = 0;
    use_Rm = 0; use_Rn = 0; use_Rram = 0;
  endtask

  task automatic put(input int rd, input int val);
    update = 1; valid_in = 1; we_in = 1;
    num_Rd_in = 3'(rd); result_in = 16'(val);
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1;
    for (int i = 0; i < 8; i++) begin
      num_Rm = 3'(i);
      use_Rm = 1;
      #1;
      n_tests++;
      if (data_Rm !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h want 0000", i, data_Rm);
      end
    end
    n_tests++;
    if (hazard !== 1'b0) begin
      n_fail++; $display("FAIL reset_hazard: got %b want 0", hazard);
    end
    n_tests++;
    if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b%b want 00", err_overflow, err_underflow);
    end
    idle();
  endtask

  task automatic test_basic();
    idle();
    put(5, 16'hBEEF);
    issue_valid = 1; issue_Rd = 5;
    tick();
    idle(); num_Rm = 5; #1;
    n_tests++;
    if (data_Rm !== 16'hBEEF || retire !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_bypass: got %h/%b want BEEF/1", data_Rm, retire);
    end
    tick();
    n_tests++;
    if (data_Rm !== 16'hBEEF || retire !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_regfile: got %h/%b want BEEF/0", data_Rm, retire);
    end
    n_tests++;
    if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL basic_nounf: got %b want 0", err_underflow);
    end
  endtask

  task automatic test_hazard();
    idle(); issue_valid = 1; issue_Rd = 3; tick();
    tick();
    idle(); use_Rn = 1; num_Rn = 3;
    put(3, 16'h1111); #1;
    n_tests++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL hz_pending2: got %b want 1", hazard);
    end
    tick();
    put(3, 16'h2222); #1;
    n_tests++;
    if (hazard !== 1'b1 || data_Rn !== 16'h1111) begin
      n_fail++;
      $display("FAIL hz_first_commit: got %b/%h want 1/1111", hazard, data_Rn);
    end
    tick();
    update = 0; valid_in = 0; we_in = 0; #1;
    n_tests++;
    if (hazard !== 1'b0 || data_Rn !== 16'h2222) begin
      n_fail++;
      $display("FAIL hz_last_commit: got %b/%h want 0/2222", hazard, data_Rn);
    end
    tick();
    n_tests++;
    if (hazard !== 1'b0 || data_Rn !== 16'h2222) begin
      n_fail++;
      $display("FAIL hz_drained: got %b/%h want 0/2222", hazard, data_Rn);
    end
  endtask

  task automatic test_same_cycle();
    idle(); issue_valid = 1; issue_Rd = 2; put(2, 16'hA5A5); tick();
    idle(); issue_valid = 1; issue_Rd = 2; use_Rn = 1; num_Rn = 2; #1;
    n_tests++;
    if (hazard !== m_hazard() || data_Rn !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL same_during: got %b/%h want %b/a5a5",
               hazard, data_Rn, m_hazard());
    end
    tick();
    issue_valid = 0; #1;
    n_tests++;
    if (hazard !== 1'b1) begin
      n_fail++; $display("FAIL same_after: got %b want 1", hazard);
    end
    put(2, 16'h5A5A); tick();
    idle(); tick();
    n_tests++;
    if (err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL same_noerr: got %b%b want 00", err_overflow, err_underflow);
    end
  endtask

  task automatic test_errors();
    idle();
    repeat (4) begin issue_valid = 1; issue_Rd = 7; tick(); end
    idle(); use_Rm = 1; num_Rm = 7; #1;
    n_tests++;
    if (err_overflow !== 1'b1 || hazard !== 1'b1) begin
      n_fail++;
      $display("FAIL err_ovf: got %b/%b want 1/1", err_overflow, hazard);
    end
    n_tests++;
    if (err_underflow !== 1'b0) begin
      n_fail++; $display("FAIL err_ovf_only: got %b want 0", err_underflow);
    end
    idle(); put(1, 16'h0042); tick();
    idle(); tick(); tick();
    n_tests++;
    if (err_underflow !== 1'b1 || err_overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b%b want 11", err_overflow, err_underflow);
    end
  endtask

  task automatic test_reset_midflight();
    idle(); issue_valid = 1; issue_Rd = 4; put(4, 16'h1234); tick();
    idle(); use_Rm = 1; num_Rm = 4; #1;
    n_tests++;
    if (retire !== 1'b1 || data_Rm !== 16'h1234) begin
      n_fail++;
      $display("FAIL mid_before: got %b/%h want 1/1234", retire, data_Rm);
    end
    #1 rst = 0;
    m_reset();
    #1;
    n_tests++;
    if (retire !== 1'b0 || hazard !== 1'b0 || data_Rm !== 16'h0000) begin
      n_fail++;
      $display("FAIL mid_during: got %b/%b/%h want 0/0/0000",
               retire, hazard, data_Rm);
    end
    @(negedge clk);
    rst = 1;
    tick();
    n_tests++;
    if (data_Rm !== 16'h0000 || retire !== 1'b0 || hazard !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_after: got %h/%b/%b want 0000/0/0",
               data_Rm, retire, hazard);
    end
    n_tests++;
    if (err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_err: got %b%b want 00", err_overflow, err_underflow);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      update      = ($urandom_range(0, 9) < 7);
      valid_in    = ($urandom_range(0, 9) < 8);
      we_in       = ($urandom_range(0, 9) < 7);
      num_Rd_in   = 3'($urandom_range(0, 7));
      result_in   = 16'($urandom);
      issue_valid = ($urandom_range(0, 9) < 4);
      issue_Rd    = 3'($urandom_range(0, 7));
      num_Rm      = 3'($urandom_range(0, 7));
      num_Rn      = 3'($urandom_range(0, 7));
      num_Rram    = 3'($urandom_range(0, 7));
      use_Rm      = 1'($urandom);
      use_Rn      = 1'($urandom);
      use_Rram    = 1'($urandom);
      #1;
      n_tests++;
      if (data_Rm !== 16'(m_data(num_Rm)) ||
          data_Rn !== 16'(m_data(num_Rn)) ||
          data_Rram !== 16'(m_data(num_Rram))) begin
        n_fail++;
        $display("FAIL rnd_data c%0d: got %h %h %h want %h %h %h", c,
                 data_Rm, data_Rn, data_Rram, 16'(m_data(num_Rm)),
                 16'(m_data(num_Rn)), 16'(m_data(num_Rram)));
      end
      n_tests++;
      if (hazard !== m_hazard() || retire !== m_full) begin
        n_fail++;
        $display("FAIL rnd_ctl c%0d: got hz%b rt%b want hz%b rt%b", c,
                 hazard, retire, m_hazard(), m_full);
      end
      n_tests++;
      if (err_overflow !== m_ovf || err_underflow !== m_unf) begin
        n_fail++;
        $display("FAIL rnd_err c%0d: got %b%b want %b%b", c,
                 err_overflow, err_underflow, m_ovf, m_unf);
      end
      if ($urandom_range(0, 39) == 0) begin
        rst = 0;
        m_reset();
        #1;
        n_tests++;
        if (retire !== 1'b0 || hazard !== 1'b0 || data_Rm !== 16'h0000) begin
          n_fail++;
          $display("FAIL rnd_rst c%0d: got %b/%b/%h want 0/0/0000", c,
                   retire, hazard, data_Rm);
        end
        @(negedge clk);
        rst = 1;
      end
      tick();
    end
  endtask

  initial begin
    idle();
    rst = 1;
    m_reset();
    #2;
    test_reset();
    test_basic();
    test_hazard();
    test_same_cycle();
    test_errors();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
